// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces
//   both press and release, and hands the key index to a consumer through
//   a valid/ack handshake.
//
// Parameters
//   SCAN_DIV      cycles each column is driven before its rows are sampled
//   DEBOUNCE_CNT  consecutive stable cycles required for press and release
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   row_in     keypad rows, active-low, asynchronous to clk
//   key_ack    consumer acknowledge
//   col_out    column drive, active-low, exactly one bit low
//   key_code   latched key index, row*4 + column
//   key_valid  key_code holds an unacknowledged key
//   overrun    sticky, a key was dropped while key_valid was high
//
// State table
//   ST_SCAN     | drive column col_q for SCAN_DIV cycles, sample rows on last
//   ST_DEBOUNCE | column held, count cycles rows match the captured pattern
//   ST_PRESSED  | key reported, column held until all rows read high
//   ST_RELEASE  | count consecutive all-high cycles before scanning resumes
// ---------------------------------------------------------------------------
module keypad_scanner #(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   input  logic       key_ack,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       overrun
);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
   localparam logic [19:0] DEB_DONE   = 20'(DEBOUNCE_CNT);

   state_t      state_q, state_d;
   logic [1:0]  col_q, col_d;
   logic [15:0] dwell_q, dwell_d;
   logic [19:0] deb_q, deb_d;
   logic [3:0]  row_cap_q, row_cap_d;
   logic [3:0]  row_meta_q, row_sync_q;
   logic [3:0]  key_code_q, key_code_d;
   logic        key_valid_q, key_valid_d;
   logic        overrun_q, overrun_d;

   logic        any_low;
   logic        complete;
   logic [1:0]  row_idx;
   logic        ack_eff;

   // -------------------------------------------------------------------------
   // State register (includes the row synchronizer, reset to released)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_SCAN;
         col_q       <= 2'd0;
         dwell_q     <= 16'd0;
         deb_q       <= 20'd0;
         row_cap_q   <= 4'hF;
         row_meta_q  <= 4'hF;
         row_sync_q  <= 4'hF;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         dwell_q     <= dwell_d;
         deb_q       <= deb_d;
         row_cap_q   <= row_cap_d;
         row_meta_q  <= row_in;
         row_sync_q  <= row_meta_q;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   assign any_low = ~&row_sync_q;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      dwell_d   = dwell_q;
      deb_d     = deb_q;
      row_cap_d = row_cap_q;
      complete  = 1'b0;

      unique case (state_q)
         ST_SCAN: begin
            if (dwell_q >= DWELL_LAST) begin
               dwell_d = 16'd0;
               if (any_low) begin
                  row_cap_d = row_sync_q;
                  deb_d     = 20'd0;
                  state_d   = ST_DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else if (dwell_q != '1) begin
               dwell_d = dwell_q + 16'd1;
            end
         end

         ST_DEBOUNCE: begin
            if (deb_q >= DEB_DONE) begin
               complete = 1'b1;
               deb_d    = 20'd0;
               state_d  = ST_PRESSED;
            end else if (row_sync_q == row_cap_q) begin
               deb_d = deb_q + 20'd1;
            end else begin
               deb_d   = 20'd0;
               dwell_d = 16'd0;
               col_d   = col_q + 2'd1;
               state_d = ST_SCAN;
            end
         end

         ST_PRESSED: begin
            if (!any_low) begin
               deb_d   = 20'd0;
               state_d = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            if (any_low) begin
               deb_d   = 20'd0;
               state_d = ST_PRESSED;
            end else if (deb_q >= DEB_DONE) begin
               deb_d   = 20'd0;
               dwell_d = 16'd0;
               col_d   = col_q + 2'd1;
               state_d = ST_SCAN;
            end else begin
               deb_d = deb_q + 20'd1;
            end
         end

         default: state_d = ST_SCAN;
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic: column decode, key encode and the valid/ack handshake
   // -------------------------------------------------------------------------
   // Lowest-index low row wins when several rows are low together.
   always_comb begin
      row_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!row_cap_q[i]) row_idx = 2'(i);
      end
   end

   assign ack_eff = key_ack & key_valid_q;

   // An ack on the same edge as a completion frees the slot, so the new key
   // is taken instead of being counted as an overrun.
   always_comb begin
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      overrun_d   = overrun_q;
      if (ack_eff) begin
         key_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end
      if (complete) begin
         if (!key_valid_q || ack_eff) begin
            key_code_d  = {row_idx, col_q};
            key_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   assign col_out   = ~(4'b0001 << col_q);
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8.
//   A keypad model pulls row r low while key (r,c) is held and column c is
//   driven. Stimulus and sampling happen on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] row_in;
   logic       key_ack;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       overrun;

   logic [15:0] keys;
   logic [3:0]  exp_col;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV     (4),
      .DEBOUNCE_CNT (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_in    (row_in),
      .key_ack   (key_ack),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .overrun   (overrun)
   );

   // Keypad matrix: key index r*4+c shorts row r to column c.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (|(keys[r*4 +: 4] & ~col_out)) row_in[r] = 1'b0;
      end
   end

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the bench on the falling edge at which rst_n is released.
   task automatic do_reset();
      rst_n   = 1'b0;
      keys    = 16'h0000;
      key_ack = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   // Key 9 (row 2, col 1) reported and left unacked, then swapped for key 14
   // (row 3, col 2). Returns on the falling edge where the swap happens.
   task automatic setup_swap();
      do_reset();
      keys[9] = 1'b1;
      step(17);
      chk1("swap_valid", key_valid, 1'b1);
      chk4("swap_code", key_code, 4'h9);
      keys     = 16'h0000;
      keys[14] = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      keys    = 16'h0000;
      key_ack = 1'b0;

      // Reset values while reset is held
      #1;
      chk4("rst_col", col_out, 4'b1110);
      chk4("rst_code", key_code, 4'h0);
      chk1("rst_valid", key_valid, 1'b0);
      chk1("rst_overrun", overrun, 1'b0);

      // Idle scan: 4 cycles per column, 16-cycle period; stray ack ignored
      do_reset();
      for (int i = 0; i < 20; i++) begin
         exp_col = ~(4'b0001 << ((i / 4) % 4));
         chk4($sformatf("scan_col_%0d", i), col_out, exp_col);
         chk1($sformatf("scan_valid_%0d", i), key_valid, 1'b0);
         key_ack = (i == 8);
         step(1);
      end
      key_ack = 1'b0;
      chk1("idle_ack_overrun", overrun, 1'b0);

      // Steady press of row 2, col 1
      do_reset();
      keys[9] = 1'b1;
      step(16);
      chk1("k9_valid_early", key_valid, 1'b0);
      step(1);
      chk1("k9_valid", key_valid, 1'b1);
      chk4("k9_code", key_code, 4'h9);
      chk4("k9_col", col_out, 4'b1101);
      step(5);
      chk4("k9_col_held", col_out, 4'b1101);
      chk1("k9_valid_held", key_valid, 1'b1);
      key_ack = 1'b1;
      step(1);
      key_ack = 1'b0;
      chk1("k9_ack_clear", key_valid, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk1($sformatf("k9_no_repeat_%0d", i), key_valid, 1'b0);
      end
      chk4("k9_col_still", col_out, 4'b1101);
      keys = 16'h0000;
      step(11);
      chk4("k9_release_pending", col_out, 4'b1101);
      step(1);
      chk4("k9_release_next_col", col_out, 4'b1011);

      // Glitch on row 0, col 0: 5 cycles low then bounce, no key
      do_reset();
      keys[0] = 1'b1;
      step(5);
      keys[0] = 1'b0;
      step(2);
      chk4("glitch_col_held", col_out, 4'b1110);
      step(1);
      chk4("glitch_next_col", col_out, 4'b1101);
      keys[0] = 1'b1;
      step(2);
      keys[0] = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         chk1($sformatf("glitch_no_valid_%0d", i), key_valid, 1'b0);
      end

      // Rows 1 and 2 low together on column 3 -> lowest row encoded
      do_reset();
      keys[7]  = 1'b1;
      keys[11] = 1'b1;
      step(24);
      chk1("multi_valid_early", key_valid, 1'b0);
      step(1);
      chk1("multi_valid", key_valid, 1'b1);
      chk4("multi_code", key_code, 4'h7);
      chk4("multi_col", col_out, 4'b0111);

      // Overrun: new key qualifies while key 9 is still unacked
      setup_swap();
      chk1("ovr_before", overrun, 1'b0);
      step(24);
      chk1("ovr_early", overrun, 1'b0);
      step(1);
      chk1("ovr_set", overrun, 1'b1);
      chk4("ovr_code_kept", key_code, 4'h9);
      chk1("ovr_valid", key_valid, 1'b1);
      key_ack = 1'b1;
      step(1);
      key_ack = 1'b0;
      chk1("ovr_ack_valid", key_valid, 1'b0);
      chk1("ovr_ack_overrun", overrun, 1'b0);

      // Ack on the same edge as completion: new key taken, no overrun
      setup_swap();
      step(24);
      key_ack = 1'b1;
      step(1);
      key_ack = 1'b0;
      chk4("same_edge_code", key_code, 4'hE);
      chk1("same_edge_valid", key_valid, 1'b1);
      chk1("same_edge_overrun", overrun, 1'b0);
      step(1);
      chk1("same_edge_valid_hold", key_valid, 1'b1);

      // Reset 3 cycles into debounce of row 1, col 2
      do_reset();
      keys[6] = 1'b1;
      step(15);
      chk4("mid_rst_col_before", col_out, 4'b1011);
      rst_n = 1'b0;
      #1;
      chk4("mid_rst_col", col_out, 4'b1110);
      chk1("mid_rst_valid", key_valid, 1'b0);
      chk4("mid_rst_code", key_code, 4'h0);
      chk1("mid_rst_overrun", overrun, 1'b0);
      step(3);
      rst_n = 1'b1;
      chk4("mid_rst_restart_col", col_out, 4'b1110);
      step(20);
      chk1("mid_rst_valid_early", key_valid, 1'b0);
      step(1);
      chk1("mid_rst_requal_valid", key_valid, 1'b1);
      chk4("mid_rst_requal_code", key_code, 4'h6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
